barrett_reduce_pipe: RTL

- Parametrised, pipelined modular reducer: out_t = in_z mod q.
- Modulus is loaded once through a config port. The block then computes k and mu = floor(4^k / q) with an internal sequential restoring divider.
- After config, a 4-stage valid/ready pipeline accepts one 2W-bit operand per cycle.
- Sits after the vedic multiplier in the modular-multiply datapath.

---
 rtl/barrett_reduce_pipe.sv | 106 ++++++++++
 1 files changed

// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe: configurable-modulus Barrett reducer with a 4-stage valid/ready pipeline
module barrett_reduce_pipe #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_valid,
  input  logic [W-1:0]   cfg_q,
  output logic           cfg_ready,
  output logic           cfg_err,
  output logic           mod_valid,
  input  logic           in_valid,
  input  logic [2*W-1:0] in_z,
  output logic           in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_t,
  input  logic           out_ready
);
  localparam int KW = $clog2(W + 1) + 1;
  typedef enum logic [1:0] {IDLE, DIV, READY} state_t;
  state_t state, state_nx;
  logic [W-1:0] q, rem;
  logic [KW-1:0] k, k_new, cnt;
  logic [W+1:0] mu, z1, z2, r3, q3, r_s3, r_a, r_b, qx;
  logic [W:0] rem_sh, q1;
  logic [2*W+2:0] p;
  logic busy, stall, cfg_hs, cfg_ok, ge, v1, v2, v3;
  assign qx = {2'b00, q};
  assign busy = v1 | v2 | v3 | out_valid;
  assign stall = out_valid & ~out_ready;
  assign cfg_ready = (state != DIV) & ~busy;
  assign cfg_hs = cfg_valid & cfg_ready;
  assign cfg_ok = cfg_hs & (cfg_q > W'(1));
  assign in_ready = mod_valid & (state == READY) & ~stall & ~cfg_hs;
  assign rem_sh = {rem, cnt == {k[KW-2:0], 1'b1}};
  assign ge = rem_sh >= {1'b0, q};
  // k of the offered modulus: MSB index plus one
  always_comb begin
    k_new = '0;
    for (int i = 0; i < W; i++) if (cfg_q[i]) k_new = KW'(i + 1);
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Next state: a good config starts a division, the last iteration ends it
  always_comb begin
    state_nx = state;
    state_nx = cfg_ok ? DIV : (state == DIV && cnt == KW'(1)) ? READY : state;
  end
  // Modulus latch and restoring division of 4^k by q, one quotient bit per cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q <= '0;
      k <= '0;
      cnt <= '0;
      rem <= '0;
      mu <= '0;
      mod_valid <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_hs & ~cfg_ok;
      if (cfg_ok) begin
        q <= cfg_q;
        k <= k_new;
        cnt <= {k_new[KW-2:0], 1'b1};
        rem <= '0;
        mu <= '0;
        mod_valid <= 1'b0;
      end else if (state == DIV) begin
        rem <= ge ? W'(rem_sh - {1'b0, q}) : rem_sh[W-1:0];
        mu <= {mu[W:0], ge};
        cnt <= cnt - KW'(1);
        if (cnt == KW'(1)) mod_valid <= 1'b1;
      end
    end
  // Quotient estimate, remainder, and final conditional subtractions
  always_comb begin
    q3 = (W+2)'(p >> (k + KW'(1)));
    r_s3 = z2 - q3 * qx;
    r_a = r3 >= qx ? r3 - qx : r3;
    r_b = r_a >= qx ? r_a - qx : r_a;
  end
  // Pipeline stages; a stall freezes all of them together
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {v1, v2, v3, out_valid} <= '0;
      z1 <= '0;
      q1 <= '0;
      z2 <= '0;
      p <= '0;
      r3 <= '0;
      out_t <= '0;
    end else if (!stall) begin
      v1 <= in_valid & in_ready;
      z1 <= in_z[W+1:0];
      q1 <= (W+1)'(in_z >> (k - KW'(1)));
      v2 <= v1;
      z2 <= z1;
      p <= (2*W+3)'(q1) * (2*W+3)'(mu);
      v3 <= v2;
      r3 <= r_s3;
      out_valid <= v3;
      out_t <= W'(r_b);
    end
endmodule
